// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader: read-side drain controller for the synchronous FIFO.
// Issues FIFO reads only when data and buffer space exist, hiding the FIFO's
// one-cycle read latency, and re-presents words on a valid/ready stream
// with out_last framing every BURST_LEN words.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   enable              permits new FIFO reads (buffer still drains when low)
//   fifo_empty          registered FIFO empty flag
//   fifo_data           FIFO read data, valid the cycle after a read strobe
//   fifo_read_enable    FIFO read strobe
//   out_valid/out_ready stream handshake
//   out_data/out_last   stream word and end-of-frame marker
//   words_sent          accepted-word counter, wraps
//   busy                buffer non-empty or a read in flight
module sync_fifo_reader #(
    parameter int WIDTH       = 8,
    parameter int BURST_LEN   = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [WIDTH-1:0]       fifo_data,
    output logic                   fifo_read_enable,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic [COUNT_WIDTH-1:0] words_sent,
    output logic                   busy
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [WIDTH-1:0]  buffer [3];
    logic [1:0]        wp;
    logic [1:0]        rp;
    logic [1:0]        count;
    logic              inflight;
    logic [BEAT_W-1:0] beat;
    logic [2:0]        pending;
    logic              capture;
    logic              fire;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read in flight already owns a buffer slot, so it counts
    // against the space check; out_ready never feeds this path.
    assign pending = {1'b0, count} + {2'b0, inflight};

    assign fifo_read_enable = enable && !fifo_empty && !reset
                              && (pending < 3'd3);

    assign capture   = inflight;
    assign out_valid = (count != 2'd0);
    assign out_data  = buffer[rp];
    assign fire      = out_valid && out_ready;
    assign out_last  = out_valid && (beat == LAST_BEAT);
    assign busy      = out_valid || inflight;

    always_ff @(posedge clock) begin
        if (reset) begin
            wp         <= 2'd0;
            rp         <= 2'd0;
            count      <= 2'd0;
            inflight   <= 1'b0;
            beat       <= '0;
            words_sent <= '0;
        end else begin
            inflight <= fifo_read_enable;
            if (capture) begin
                wp <= ptr_inc(wp);
            end
            if (fire) begin
                rp         <= ptr_inc(rp);
                words_sent <= words_sent + 1'b1;
                beat       <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
            end
            unique case ({capture, fire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Data storage needs no reset; occupancy alone decides validity,
    // so a word captured alongside reset is simply forgotten.
    always_ff @(posedge clock) begin
        if (capture) begin
            buffer[wp] <= fifo_data;
        end
    end

endmodule

// File: tb/tb_sync_fifo_reader.sv
// tb_sync_fifo_reader: directed bench for sync_fifo_reader with a registered
// FIFO model; one instance at defaults, one with BURST_LEN=1, COUNT_WIDTH=4.
module tb_sync_fifo_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        out_ready = 1'b0;

    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_read_enable;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] words_sent;
    logic        busy;

    logic        fifo_empty2 = 1'b1;
    logic [7:0]  fifo_data2 = 8'h00;
    logic        fifo_read_enable2;
    logic        out_valid2;
    logic [7:0]  out_data2;
    logic        out_last2;
    logic [3:0]  words_sent2;
    logic        busy2;

    sync_fifo_reader #(.WIDTH(8), .BURST_LEN(16), .COUNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_read_enable(fifo_read_enable),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .words_sent(words_sent), .busy(busy)
    );

    sync_fifo_reader #(.WIDTH(8), .BURST_LEN(1), .COUNT_WIDTH(4)) dut_b1 (
        .clock(clock), .reset(reset), .enable(enable),
        .fifo_empty(fifo_empty2), .fifo_data(fifo_data2),
        .fifo_read_enable(fifo_read_enable2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_last(out_last2),
        .words_sent(words_sent2), .busy(busy2)
    );

    always #5 clock = ~clock;

    // Registered FIFO model: empty flag and data update on the read edge.
    logic [7:0] mem [64];
    int         head = 0;
    int         tail = 0;
    logic       flush = 1'b0;
    logic       underrun = 1'b0;

    always @(posedge clock) begin
        if (flush) begin
            head       <= 0;
            fifo_empty <= 1'b1;
        end else if (fifo_read_enable) begin
            if (fifo_empty) underrun <= 1'b1;
            fifo_data  <= mem[head];
            head       <= head + 1;
            fifo_empty <= (tail == head + 1);
        end else begin
            fifo_empty <= (tail == head);
        end
    end

    // Counting source for the second instance.
    int   src2_total = 0;
    int   src2_taken = 0;
    logic underrun2 = 1'b0;

    always @(posedge clock) begin
        if (fifo_read_enable2) begin
            if (fifo_empty2) underrun2 <= 1'b1;
            fifo_data2  <= 8'(src2_taken);
            src2_taken  <= src2_taken + 1;
            fifo_empty2 <= (src2_taken + 1 >= src2_total);
        end else begin
            fifo_empty2 <= (src2_taken >= src2_total);
        end
    end

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int rd_pulses = 0;
    int first_rd = -1;
    int n2 = 0;
    logic [7:0] got_d [$];
    logic       got_l [$];
    int         got_c [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic rdy);
        @(negedge clock);
        enable    = en;
        out_ready = rdy;
        #1;
        cyc++;
        if (fifo_read_enable) begin
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
            got_c.push_back(cyc);
        end
        if (out_valid2 && out_ready) begin
            chk("b1_last", 32'(out_last2), 32'd1);
            chk("b1_data", 32'(out_data2), 32'(n2));
            n2++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b1;
        tail  = 0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        reset = 1'b0;
        flush = 1'b0;
        got_d.delete();
        got_l.delete();
        got_c.delete();
        rd_pulses = 0;
        first_rd  = -1;
        cyc       = 0;
        n2        = 0;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) mem[tail + i] = 8'(i);
        tail = tail + n;
    endtask

    typedef struct packed {
        logic        rdy;
        logic        e_rd;
        logic        e_valid;
        logic [7:0]  e_data;
        logic        e_busy;
        logic [15:0] e_ws;
    } vec_t;

    vec_t vecs [19];

    initial begin
        int guard;

        // Backpressure: 10 words, stall 8 cycles, then release.
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 16'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 16'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 16'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 16'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 16'd1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 16'd2};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 16'd3};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 16'd4};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 8'h05, 1'b1, 16'd5};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 8'h06, 1'b1, 16'd6};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 16'd7};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 8'h08, 1'b1, 16'd8};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 8'h09, 1'b1, 16'd9};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd10};

        // Reset state, and no reads while reset holds a non-empty FIFO.
        reset = 1'b1;
        flush = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("rst_rd", 32'(fifo_read_enable), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ws", 32'(words_sent), 32'd0);
        flush = 1'b0;
        load(4);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("rst_empty_seen", 32'(fifo_empty), 32'd0);
        chk("rst_hold_rd", 32'(fifo_read_enable), 32'd0);
        chk("rst_hold_busy", 32'(busy), 32'd0);

        // Table-driven backpressure sequence.
        do_reset();
        load(10);
        for (int i = 0; i < 19; i++) begin
            step(1'b1, vecs[i].rdy);
            chk($sformatf("bp_rd[%0d]", i),
                32'(fifo_read_enable), 32'(vecs[i].e_rd));
            chk($sformatf("bp_valid[%0d]", i),
                32'(out_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid)
                chk($sformatf("bp_data[%0d]", i),
                    32'(out_data), 32'(vecs[i].e_data));
            chk($sformatf("bp_last[%0d]", i), 32'(out_last), 32'd0);
            chk($sformatf("bp_busy[%0d]", i),
                32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("bp_ws[%0d]", i),
                32'(words_sent), 32'(vecs[i].e_ws));
            if (i == 7) chk("bp_stall_reads", rd_pulses, 3);
        end
        chk("bp_count", got_d.size(), 10);
        for (int i = 0; i < got_d.size(); i++)
            chk($sformatf("bp_order[%0d]", i), 32'(got_d[i]), i);

        // Streaming 20 words with out_ready held high.
        do_reset();
        load(20);
        repeat (30) step(1'b1, 1'b1);
        chk("st_count", got_d.size(), 20);
        if (got_c.size() > 0)
            chk("st_latency", got_c[0] - first_rd, 2);
        for (int i = 0; i < got_d.size(); i++) begin
            chk($sformatf("st_data[%0d]", i), 32'(got_d[i]), i);
            chk($sformatf("st_last[%0d]", i),
                32'(got_l[i]), 32'(i == 15));
            chk($sformatf("st_cycle[%0d]", i), got_c[i] - got_c[0], i);
        end
        chk("st_ws", 32'(words_sent), 32'd20);

        // Reset with two words buffered and one in flight.
        do_reset();
        load(10);
        repeat (4) step(1'b1, 1'b0);
        chk("mr_pre_valid", 32'(out_valid), 32'd1);
        chk("mr_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0);
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_ws", 32'(words_sent), 32'd0);
        repeat (20) step(1'b1, 1'b1);
        chk("mr_count", got_d.size(), 7);
        for (int i = 0; i < got_d.size(); i++)
            chk($sformatf("mr_data[%0d]", i), 32'(got_d[i]), i + 3);
        chk("mr_ws_end", 32'(words_sent), 32'd7);

        // Empty FIFO for 50 cycles.
        do_reset();
        repeat (50) step(1'b1, 1'b1);
        chk("em_reads", rd_pulses, 0);
        chk("em_valid", 32'(out_valid), 32'd0);
        chk("em_underrun", 32'(underrun), 32'd0);

        // Enable dropped after the 5th read of a 16-word frame.
        do_reset();
        load(16);
        guard = 0;
        while (rd_pulses < 5 && guard < 20) begin
            step(1'b1, 1'b1);
            guard++;
        end
        chk("en_reads", rd_pulses, 5);
        repeat (8) step(1'b0, 1'b1);
        chk("en_drained", got_d.size(), 5);
        chk("en_valid_off", 32'(out_valid), 32'd0);
        chk("en_busy_off", 32'(busy), 32'd0);
        chk("en_no_reads", rd_pulses, 5);
        repeat (30) step(1'b1, 1'b1);
        chk("en_count", got_d.size(), 16);
        for (int i = 0; i < got_d.size(); i++) begin
            chk($sformatf("en_data[%0d]", i), 32'(got_d[i]), i);
            chk($sformatf("en_last[%0d]", i),
                32'(got_l[i]), 32'(i == 15));
        end
        chk("en_ws", 32'(words_sent), 32'd16);

        // Counter wrap and single-word frames on the second instance.
        do_reset();
        src2_total = 17;
        repeat (30) step(1'b1, 1'b1);
        chk("b1_count", n2, 17);
        chk("b1_ws_wrap", 32'(words_sent2), 32'd1);
        chk("b1_idle", 32'(busy2), 32'd0);

        chk("underrun", 32'(underrun), 32'd0);
        chk("underrun2", 32'(underrun2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
